// File: rtl/mux_n_skid_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_n_skid_if
// Brief    : Upstream/downstream handshake bundle for mux_n_skid.
// Revision : 1.0 - initial release
// ============================================================================
interface mux_n_skid_if #(
    parameter int WIDTH = 32,
    parameter int N     = 16
);
    localparam int SEL_W = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]   in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mux_n_skid.sv
`default_nettype none
// ============================================================================
// Module   : mux_n_skid
// Brief    : N-way WIDTH-bit selector feeding a 2-entry skid FIFO of {sel,data}.
//            Define MUX_SEL_CHECK_EN to drop out-of-range beats and flag sel_err.
// Revision : 1.0 - initial release
// ============================================================================
module mux_n_skid #(
    parameter int WIDTH = 32,
    parameter int N     = 16
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    mux_n_skid_if.slave    bus
`ifdef MUX_SEL_CHECK_EN
    ,
    output logic           sel_err
`endif
);
    localparam int SEL_W = $clog2(N);

    logic [1:0]       r_count;
    logic             r_wptr;
    logic             r_rptr;
    logic [WIDTH-1:0] r_data [2];
    logic [SEL_W-1:0] r_sel  [2];

    logic [WIDTH-1:0] w_sel_data;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;

    // Unmatched select codes leave the result at zero.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (bus.in_sel == k[SEL_W-1:0]) begin
                w_sel_data = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.in_ready  = (r_count != 2'd2);
    assign bus.out_valid = (r_count != 2'd0);
    assign bus.out_data  = r_data[r_rptr];
    assign bus.out_sel   = r_sel[r_rptr];

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_pop    = bus.out_valid && bus.out_ready;

`ifdef MUX_SEL_CHECK_EN
    localparam logic [SEL_W:0] c_n_chan = (SEL_W+1)'(N);

    logic w_in_range;
    logic r_sel_err;

    assign w_in_range = ({1'b0, bus.in_sel} < c_n_chan);
    assign w_push     = w_accept && w_in_range;
    assign sel_err    = r_sel_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && !w_in_range) begin
            r_sel_err <= 1'b1;
        end
    end
`else
    assign w_push = w_accept;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= 2'd0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_sel[0]  <= '0;
            r_sel[1]  <= '0;
        end else begin
            if (w_push) begin
                r_data[r_wptr] <= w_sel_data;
                r_sel[r_wptr]  <= bus.in_sel;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mux_n_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_n_skid
// Brief    : Scoreboard bench for mux_n_skid (N=12 so out-of-range selects exist).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_n_skid;
    localparam int WIDTH = 32;
    localparam int N     = 12;
    localparam int SEL_W = $clog2(N);
    localparam int BEAT_W = SEL_W + WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [WIDTH-1:0] ch [N];
    logic [BEAT_W-1:0] sb [$];
    int n_checks = 0;
    int n_pass   = 0;
    bit prev_stall = 1'b0;
    logic [BEAT_W-1:0] prev_beat = '0;
    bit rnd_on = 1'b0;

    mux_n_skid_if #(.WIDTH(WIDTH), .N(N)) b ();

`ifdef MUX_SEL_CHECK_EN
    logic sel_err;
    mux_n_skid #(.WIDTH(WIDTH), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(b), .sel_err(sel_err));
`else
    mux_n_skid #(.WIDTH(WIDTH), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
`endif

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign b.in_data[k*WIDTH +: WIDTH] = ch[k];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    endtask

    // Drive one beat and hold it until accepted; returns at posedge+1.
    task automatic send(input logic [SEL_W-1:0] sel, input logic [WIDTH-1:0] val);
        int waited = 0;
        b.in_sel = sel;
        if (sel < N) ch[sel] = val;
        b.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (b.in_ready) break;
            waited++;
            if (waited > 200) begin
                n_checks++;
                $display("FAIL send_timeout: got in_ready=0 required 1 within 200 cycles");
                b.in_valid = 1'b0;
                return;
            end
        end
        if (sel < N) sb.push_back({sel, val});
`ifndef MUX_SEL_CHECK_EN
        else sb.push_back({sel, {WIDTH{1'b0}}});
`endif
        @(posedge clk);
        #1;
        b.in_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        while ((sb.size() != 0 || b.out_valid) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge rst_n) prev_stall = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_valid", 64'(b.out_valid), 64'd1);
                check("hold_beat", 64'({b.out_sel, b.out_data}), 64'(prev_beat));
            end
            if (b.out_valid && b.out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got sel=%0d data=%0h required no beat",
                             b.out_sel, b.out_data);
                end else begin
                    check("out_beat", 64'({b.out_sel, b.out_data}), 64'(sb.pop_front()));
                end
            end
            prev_stall = b.out_valid && !b.out_ready;
            prev_beat  = {b.out_sel, b.out_data};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < N; k++) ch[k] = '0;
        b.in_sel    = '0;
        b.in_valid  = 1'b0;
        b.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(b.out_valid), 64'd0);
        check("rst_out_data", 64'(b.out_data), 64'd0);
        check("rst_out_sel", 64'(b.out_sel), 64'd0);
        check("rst_in_ready", 64'(b.in_ready), 64'd1);
`ifdef MUX_SEL_CHECK_EN
        check("rst_sel_err", 64'(sel_err), 64'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat, 1-cycle latency
        send(SEL_W'(5), 32'hDEADBEEF);
        @(negedge clk);
        check("t1_valid", 64'(b.out_valid), 64'd1);
        @(negedge clk);
        check("t1_valid_after", 64'(b.out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Back-pressure: third beat held until the head drains
        b.out_ready = 1'b0;
        send(SEL_W'(0), 32'h1);
        send(SEL_W'(1), 32'h2);
        fork
            send(SEL_W'(2), 32'h3);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("t2_full_in_ready", 64'(b.in_ready), 64'd0);
                end
                @(posedge clk);
                #1;
                b.out_ready = 1'b1;
            end
        join
        drain();

        // Simultaneous push and pop at count=1
        b.out_ready = 1'b0;
        send(SEL_W'(0), 32'h100);
        b.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(SEL_W'(i), 32'h200 + 32'(i));
            check("t3_in_ready", 64'(b.in_ready), 64'd1);
            check("t3_out_valid", 64'(b.out_valid), 64'd1);
        end
        drain();

        // Out-of-range select
        send(SEL_W'(13), 32'hCAFEF00D);
        @(negedge clk);
`ifdef MUX_SEL_CHECK_EN
        check("t4_sel_err", 64'(sel_err), 64'd1);
        check("t4_out_valid", 64'(b.out_valid), 64'd0);
`else
        check("t4_out_valid", 64'(b.out_valid), 64'd1);
`endif
        drain();

        // Asynchronous reset while full
        b.out_ready = 1'b0;
        send(SEL_W'(3), 32'h33);
        send(SEL_W'(4), 32'h44);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_out_valid", 64'(b.out_valid), 64'd0);
        check("t5_in_ready", 64'(b.in_ready), 64'd1);
        sb.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_out_valid_post", 64'(b.out_valid), 64'd0);
`ifdef MUX_SEL_CHECK_EN
        check("t5_sel_err_post", 64'(sel_err), 64'd0);
`endif
        @(posedge clk);
        #1;

        // Random valid/ready traffic against the queue model
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge clk);
                #1;
                b.out_ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            for (int k = 0; k < N; k++) ch[k] = $urandom;
            send(SEL_W'($urandom_range(0, 15)), $urandom);
        end
        rnd_on = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        b.out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
